data_mem_bank: RTL
==================

# data_mem_bank

Parametrised data memory for the nRisc datapath, the successor to the fixed 8-bit memory bank. It stores DEPTH words of DATA_W bits and accepts one load or store per cycle through a request/ready handshake. Loads return data through a pipelined read path of configurable latency. After reset, an optional hardware clear sequence zeroes the array. It sits between the ALU/address path and the write-back mux.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
- READ_LAT, 1, load latency in cycles; legal range 1..4
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents undefined after reset
- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- MemRead  in  1  load request
- MemWrite  in  1  store request
- Addr  in  ADDR_W  word address
- WriteData  in  DATA_W  store data
- ReqReady  out  1  bank accepts requests this cycle
- ReadData  out  DATA_W  load result; holds last value when ReadValid=0
- ReadValid  out  1  one-cycle pulse per completed load
- Busy  out  1  hardware clear in progress
- Error  out  1  one-cycle pulse on a MemRead+MemWrite collision

## Operation
- FSM states: ST_CLEAR, ST_RUN.
- Reset (reset_n=0 at an edge):
  - Next state is ST_CLEAR if CLEAR_ON_RESET, otherwise ST_RUN.
  - Clear counter goes to 0.
  - Read pipeline is flushed.
- ST_CLEAR:
  - Each cycle, write 0 to word[counter] and increment the counter.
  - After the write to word DEPTH-1, go to ST_RUN.
  - Busy=1 and ReqReady=0 throughout.
  - MemRead and MemWrite are ignored: no write, no ReadValid, no Error.
- ST_RUN:
  - Busy=0 and ReqReady=1.
  - A request is accepted when ReqReady=1 and (MemRead or MemWrite) is high.
- Store: word[Addr] <= WriteData at the acceptance edge.
- Load: word[Addr] is sampled at the acceptance edge. The sampled value and a valid bit then pass through READ_LAT-1 further register stages.
- Ordering: a load sees every store accepted in an earlier cycle. Stores are never reordered.
- Collision (MemRead and MemWrite both high):
  - The store is performed and the load is dropped.
  - Error pulses for exactly the cycle after acceptance.
- Addr is full-range, so no out-of-range case exists. The clear counter is ADDR_W+1 bits wide so DEPTH-1 is detected without wrap.

## Timing
- Reset values:
  - ReadData=0, ReadValid=0, Error=0.
  - Busy=CLEAR_ON_RESET and ReqReady=!CLEAR_ON_RESET, both from the first cycle after the reset edge.
- Clear duration: exactly DEPTH cycles with Busy=1. ReqReady rises in cycle DEPTH after the reset is released.
- Load latency: a load accepted in cycle N produces ReadValid=1 with ReadData in cycle N+READ_LAT.
- Throughput: one request per cycle. Back-to-back loads give a contiguous ReadValid train.
- Store latency: 1. A load in cycle N+1 to the same address returns the cycle-N store data.
- Reset in mid-operation, including mid-clear or with loads in flight:
  - In-flight loads are discarded; ReadValid=0 in the next cycle.
  - The clear restarts from word 0.

## Structure
- The package data_mem_pkg holds:
  - the state typedef (ST_CLEAR, ST_RUN)
  - READ_LAT_MIN=1 and READ_LAT_MAX=4 for elaboration-time parameter checks.
- Sub-module read_pipe: a DATA_W+1 bit delay line, READ_LAT-1 stages deep, with synchronous active-low flush of the valid bits. Its data bits are not reset.
- The array is a plain reg array so it can be inferred as distributed RAM or flops.

## Test plan
- Default parameters, reset released: Busy=1 for 256 cycles, then ReqReady=1. Loading addresses 0x00, 0x7F and 0xFF returns 0x00 each.
- Store 0xA5 to 0x10 in cycle N, load 0x10 in cycle N+1 with READ_LAT=3: ReadValid=1 and ReadData=0xA5 in cycle N+4.
- Collision: MemRead=MemWrite=1, Addr=0x20, WriteData=0x3C. Error pulses once and no ReadValid is produced. A later load of 0x20 returns 0x3C.
- READ_LAT=2, loads in 8 consecutive cycles to 0x00..0x07 preloaded with i*3: eight contiguous ReadValid pulses returning 0x00..0x15 in order.
- reset_n low for one cycle with 2 loads in flight and mid-clear: no ReadValid afterwards, and Busy stays high for a full 256 cycles from the release.
- CLEAR_ON_RESET=0: ReqReady=1 in the first cycle after reset, Busy stays 0, and a store then load of 0xFF at 0x01 returns 0xFF.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and limits for the nRisc data memory bank.
// Holds the FSM state encoding and the legal range of the load latency parameter.
package data_mem_pkg;

   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 4;

   typedef logic [0:0] state_t;
   localparam state_t ST_CLEAR = 1'b0;
   localparam state_t ST_RUN   = 1'b1;

endpackage

// File: rtl/data_mem_bank_read_pipe.sv
// Delay line for {valid, data} of the load path, STAGES registers deep.
// Only the valid bits are flushed; the data bits ride along unreset.
module read_pipe #(
   parameter int DATA_W = 8,
   parameter int STAGES = 1
) (
   input  logic              clock,
   input  logic              flush_n,
   input  logic [DATA_W:0]   din,
   output logic [DATA_W:0]   dout
);

   logic [DATA_W-1:0] data_q [STAGES];
   logic [STAGES-1:0] valid_q;

   always_ff @(posedge clock) begin
      data_q[0] <= din[DATA_W-1:0];
      for (int i = 1; i < STAGES; i++) begin
         data_q[i] <= data_q[i-1];
      end
   end

   always_ff @(posedge clock) begin
      if (!flush_n) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= din[DATA_W];
         for (int i = 1; i < STAGES; i++) begin
            valid_q[i] <= valid_q[i-1];
         end
      end
   end

   assign dout = {valid_q[STAGES-1], data_q[STAGES-1]};

endmodule

// File: rtl/data_mem_bank.sv
// Parametrised data memory for the nRisc datapath: one load or store per cycle,
// pipelined loads of READ_LAT cycles, optional zeroing sweep after reset.
module data_mem_bank
   import data_mem_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 8,
   parameter int READ_LAT       = 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WriteData,
   output logic              ReqReady,
   output logic [DATA_W-1:0] ReadData,
   output logic              ReadValid,
   output logic              Busy,
   output logic              Error
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CW    = ADDR_W + 1;
   localparam logic [ADDR_W:0] CLR_LAST = CW'(DEPTH - 1);

   if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
      $error("data_mem_bank: READ_LAT must be within 1..4");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   state_t            state;
   logic [ADDR_W:0]   clr_cnt;
   logic              in_run;
   logic              acc_wr;
   logic              acc_rd;
   logic              collide;
   logic [DATA_W:0]   pipe_in;
   logic [DATA_W:0]   pipe_out;

   assign in_run   = (state == ST_RUN);
   assign ReqReady = in_run;
   assign Busy     = !in_run;

   // A collision keeps the store and drops the load; nothing is accepted on a reset edge.
   assign acc_wr  = in_run && reset_n && MemWrite;
   assign acc_rd  = in_run && reset_n && MemRead && !MemWrite;
   assign collide = in_run && reset_n && MemRead && MemWrite;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
         clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
         clr_cnt <= clr_cnt + CW'(1);
         if (clr_cnt == CLR_LAST) begin
            state <= ST_RUN;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset_n && state == ST_CLEAR) begin
         mem[clr_cnt[ADDR_W-1:0]] <= '0;
      end else if (acc_wr) begin
         mem[Addr] <= WriteData;
      end
   end

   // The output register is the last latency stage, so the pipe holds READ_LAT-1 stages.
   assign pipe_in = {acc_rd, mem[Addr]};

   if (READ_LAT > 1) begin : g_pipe
      read_pipe #(
         .DATA_W (DATA_W),
         .STAGES (READ_LAT - 1)
      ) u_read_pipe (
         .clock   (clock),
         .flush_n (reset_n),
         .din     (pipe_in),
         .dout    (pipe_out)
      );
   end else begin : g_no_pipe
      assign pipe_out = pipe_in;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ReadValid <= 1'b0;
         ReadData  <= '0;
         Error     <= 1'b0;
      end else begin
         ReadValid <= pipe_out[DATA_W];
         if (pipe_out[DATA_W]) begin
            ReadData <= pipe_out[DATA_W-1:0];
         end
         Error <= collide;
      end
   end

endmodule
